// File: rtl/updown_counter_param_if.sv
// Control/status bundle for updown_counter_param.
// UPDOWN_COUNTER_STICKY_EN adds the ovf_clr/sticky pair.
interface updown_counter_param_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 2
);
    logic              en;
    logic              load;
    logic [WIDTH-1:0]  d;
    logic              updown;
    logic [STEP_W-1:0] step;
    logic              sat;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              ovf;
    logic              udf;
`ifdef UPDOWN_COUNTER_STICKY_EN
    logic              ovf_clr;
    logic              sticky;
`endif

`ifdef UPDOWN_COUNTER_STICKY_EN
    modport master (
        output en, load, d, updown, step, sat, ovf_clr,
        input  count, tc, ovf, udf, sticky
    );
    modport slave (
        input  en, load, d, updown, step, sat, ovf_clr,
        output count, tc, ovf, udf, sticky
    );
`else
    modport master (
        output en, load, d, updown, step, sat,
        input  count, tc, ovf, udf
    );
    modport slave (
        input  en, load, d, updown, step, sat,
        output count, tc, ovf, udf
    );
`endif
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised modulo up/down counter with step, wrap/saturate mode and ovf/udf pulses.
// Optional sticky overflow flag under UPDOWN_COUNTER_STICKY_EN.
module updown_counter_param #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16,
    parameter int unsigned STEP_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    updown_counter_param_if.slave bus
);
    localparam int unsigned AW  = WIDTH + 1;
    localparam int unsigned MAX = MODULUS - 1;
    localparam logic [AW-1:0] MAX_X = AW'(MAX);
    localparam logic [AW-1:0] MOD_X = AW'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_q;
    logic             ovf_nxt;
    logic             udf_q;
    logic             udf_nxt;

    // One extra bit so count+step and count+MODULUS never truncate.
    logic [AW-1:0] cnt_x;
    logic [AW-1:0] step_x;
    logic [AW-1:0] d_x;
    logic [AW-1:0] up_sum;
    logic [AW-1:0] dn_wrap;

    assign cnt_x   = {1'b0, count_q};
    assign step_x  = AW'(bus.step);
    assign d_x     = {1'b0, bus.d};
    assign up_sum  = cnt_x + step_x;
    assign dn_wrap = cnt_x + MOD_X - step_x;

    // Next count and boundary-crossing flags; reset is applied in the register.
    always_comb begin
        count_nxt = count_q;
        ovf_nxt   = 1'b0;
        udf_nxt   = 1'b0;
        if (bus.load) begin
            count_nxt = (d_x > MAX_X) ? WIDTH'(MAX) : bus.d;
        end else if (bus.en) begin
            if (bus.updown) begin
                if (up_sum > MAX_X) begin
                    ovf_nxt   = 1'b1;
                    count_nxt = bus.sat ? WIDTH'(MAX) : WIDTH'(up_sum - MOD_X);
                end else begin
                    count_nxt = WIDTH'(up_sum);
                end
            end else begin
                if (cnt_x >= step_x) begin
                    count_nxt = WIDTH'(cnt_x - step_x);
                end else begin
                    udf_nxt   = 1'b1;
                    count_nxt = bus.sat ? '0 : WIDTH'(dn_wrap);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            ovf_q   <= ovf_nxt;
            udf_q   <= udf_nxt;
        end
    end

    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
    assign bus.tc    = (bus.updown && (count_q == WIDTH'(MAX))) ||
                       (!bus.updown && (count_q == '0));

`ifdef UPDOWN_COUNTER_STICKY_EN
    logic sticky_q;

    // A set event on the same edge as ovf_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (ovf_nxt || udf_nxt) begin
            sticky_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.sticky = sticky_q;
`endif
endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised successor to the team's 4-bit loadable up/down counter. Adds:
- configurable width and modulus (e.g. a decade counter);
- programmable step size;
- runtime wrap/saturate mode;
- count enable;
- terminal-count and registered overflow/underflow pulses.

It is used as a general-purpose event, timer and address counter in datapath and control blocks.

Parameters:
- WIDTH, 4, bit width of d and count.
- MODULUS, 16, count range is 0..MODULUS-1 (MAX = MODULUS-1). Constraint: 2 <= MODULUS <= 2**WIDTH.
- STEP_W, 2, bit width of step. Constraint: 2**STEP_W - 1 < MODULUS.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, count enable; sampled each rising edge.
- load, input, 1, synchronous parallel load of d.
- d, input, WIDTH, load value.
- updown, input, 1, direction: 1 = up, 0 = down.
- step, input, STEP_W, increment/decrement magnitude. 0 = hold.
- sat, input, 1, boundary mode: 1 = saturate at 0/MAX, 0 = wrap modulo MODULUS.
- count, output, WIDTH, current count (registered).
- tc, output, 1, terminal count (combinational from count and updown).
- ovf, output, 1, registered one-cycle pulse: an up-step crossed MAX.
- udf, output, 1, registered one-cycle pulse: a down-step crossed 0.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates occur on the rising edge of clk.
- Priority per edge: rst > load > en. When none is active, count holds.
- rst = 1: count <= 0, ovf <= 0, udf <= 0. This takes effect on the edge it is sampled, regardless of load/en, including mid-count.
- load = 1 (rst = 0):
  - count <= d if d <= MAX, else count <= MAX (clamp);
  - ovf <= 0, udf <= 0;
  - en, step and updown are ignored that cycle.
- en = 1, load = 0, up (updown = 1):
  - If count + step <= MAX: count <= count + step.
  - Otherwise the step crosses MAX, and ovf <= 1 for one cycle:
    - sat = 0: count <= count + step - MODULUS;
    - sat = 1: count <= MAX.
- en = 1, load = 0, down (updown = 0):
  - If count >= step: count <= count - step.
  - Otherwise the step crosses 0, and udf <= 1 for one cycle:
    - sat = 0: count <= count + MODULUS - step;
    - sat = 1: count <= 0.
- Saturate at a boundary: with sat = 1, count already at MAX, updown = 1, step != 0, ovf still pulses every enabled cycle. The same applies to udf at 0 when counting down.
- step = 0 with en = 1: count holds; ovf = udf = 0.
- ovf/udf are 0 on any cycle without a qualifying enabled step. They are never both 1.
- Arithmetic: computed at WIDTH+1 bits minimum, so count + step never truncates before comparison with MAX.
- tc = 1 when (updown = 1 and count == MAX) or (updown = 0 and count == 0). It is purely combinational and independent of en.
- Latency: count reflects load/step one cycle after the sampling edge. ovf/udf align with the updated count.
- Inputs changing mid-cycle have no effect until the next edge. No X propagation from d when load = 0.

Optional Feature:
Macro: UPDOWN_COUNTER_STICKY_EN.
- Defined:
  - adds input port ovf_clr (1 bit) and output port sticky (1 bit);
  - sticky <= 1 on any cycle ovf or udf is set;
  - cleared to 0 by rst or by ovf_clr = 1;
  - a simultaneous set event and ovf_clr = 1 leaves sticky = 1 (set wins);
  - sticky resets to 0.
- Not defined: neither port exists, and behaviour is otherwise identical.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10, STEP_W=2.
- Reset: rst=1 for 2 cycles with en=1, load=1, d=7 -> count=0, ovf=udf=0. Release rst, en=1, step=1, up -> count 1, 2, 3 on successive edges.
- Wrap up: load d=8, then en=1, step=1, up, sat=0 -> count 9 (tc=1), then 0 with ovf=1 for exactly one cycle, then 1 with ovf=0. Then with step=3 from 8 -> count 1, ovf=1.
- Wrap down: load d=1, step=2, down, sat=0 -> count 9, udf=1. Next count 7, udf=0. Load d=0 with down -> tc=1.
- Saturate: sat=1, load d=8, step=3, up -> count 9 with ovf=1. The next enabled edge holds 9 with ovf=1 again. Then down, step=3 from 2 -> count 0, udf=1.
- Load priority and clamp:
  - load=1, en=1, d=13 -> count=9 (clamped), no ovf;
  - load=1 and rst=1 together -> count=0;
  - en=0 or step=0 -> count holds over 5 cycles.
- Sticky (macro defined): trigger ovf -> sticky=1 persists after ovf drops. ovf_clr=1 -> sticky=0. ovf_clr=1 on the same edge as a wrap -> sticky=1.
